// File: rtl/special_regs_pkg.sv
// special_regs_pkg: PSR bit positions and PC sequencing opcodes shared by the special-register block.
package special_regs_pkg;
    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;
    localparam int PSR_I = 9;
    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_LOAD = 2'b10,
        PC_REL  = 2'b11
    } pc_op_e;
endpackage

// File: rtl/context_stack.sv
// context_stack: LIFO of saved interrupt contexts; push when full and pop when empty are ignored.
module context_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [1 << IW];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top;
    assign top   = ptr - 1'b1;
    assign dout  = mem[top[IW-1:0]];
    assign full  = ptr == PW'(DEPTH);
    assign empty = ptr == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (push && !full) begin
            mem[ptr[IW-1:0]] <= din;
            ptr              <= ptr + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
        end
    end
endmodule

// File: rtl/special_regs.sv
// special_regs: PC, INSTR and PSR registers with interrupt entry/return saving {PSR, PC} on a context stack.
module special_regs
    import special_regs_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] PC_RESET    = '0,
    parameter logic [ADDR_W-1:0] INT_VEC     = ADDR_W'(16'h0010)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pc_op,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              instr_en,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              cmp_f_en,
    input  logic              of_f_en,
    input  logic              z_f_en,
    input  logic              C_in,
    input  logic              L_in,
    input  logic              F_in,
    input  logic              Z_in,
    input  logic              N_in,
    input  logic              ie_set,
    input  logic              ie_clr,
    input  logic              int_req,
    input  logic              rti,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] psr,
    output logic [DATA_W-1:0] instr,
    output logic              int_ack,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);
    logic [DATA_W-1:0]        psr_n;
    logic [DATA_W-1:0]        psr_int;
    logic [ADDR_W-1:0]        pc_n;
    logic [DATA_W+ADDR_W-1:0] ctx_out;
    logic                     do_pop;
    logic                     int_ok;
    logic                     take;
    always_comb begin
        psr_n = psr;
        if (cmp_f_en) begin
            psr_n[PSR_L] = L_in;
            psr_n[PSR_N] = N_in;
        end
        if (of_f_en) begin
            psr_n[PSR_F] = F_in;
            psr_n[PSR_C] = C_in;
        end
        if (z_f_en)
            psr_n[PSR_Z] = Z_in;
        psr_n[PSR_I] = ie_clr ? 1'b0 : ie_set ? 1'b1 : psr[PSR_I];
        psr_int = psr_n;
        psr_int[PSR_I] = 1'b0;
        pc_n = pc_op == PC_INC  ? pc + 1'b1 :
               pc_op == PC_LOAD ? pc_in :
               pc_op == PC_REL  ? pc + pc_in : pc;
    end
    // A valid rti pre-empts everything, including a concurrent interrupt request.
    assign do_pop = rti && !stack_empty;
    assign int_ok = !do_pop && int_req && psr[PSR_I];
    assign take   = int_ok && !stack_full;
    context_stack #(
        .W     (DATA_W + ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (take),
        .pop   (do_pop),
        .din   ({psr_n, pc_n}),
        .dout  (ctx_out),
        .full  (stack_full),
        .empty (stack_empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= PC_RESET;
            psr       <= '0;
            instr     <= '0;
            int_ack   <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            if (instr_en)
                instr <= instr_in;
            pc      <= do_pop ? ctx_out[ADDR_W-1:0] : take ? INT_VEC : pc_n;
            psr     <= do_pop ? ctx_out[DATA_W+ADDR_W-1:ADDR_W] : take ? psr_int : psr_n;
            int_ack <= take;
            if ((rti && stack_empty) || (int_ok && stack_full))
                stack_err <= 1'b1;
        end
    end
endmodule
